stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Timekeeping core of the stopwatch; sits directly upstream of the 7-segment display driver.
- Maintains MM:SS as four BCD digits and feeds them straight to the driver's digit inputs.
- Handles run/pause, synchronous clear and adjust mode. Adjust mode increments the selected field at 2 Hz with no carry.
- Advances only on single-cycle tick enables from the clock divider; it creates no derived clocks.

Parameters:
- SEC_MAX, 59, terminal value of the seconds field (BCD wrap point).
- MIN_MAX, 59, terminal value of the minutes field.
- RUN_AT_RESET, 1, initial state after reset: 1 = RUN, 0 = PAUSED.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle enable, 1 Hz, for normal counting
- tick_2hz  in  1  one-cycle enable, 2 Hz, for adjust increments
- pause  in  1  debounced one-cycle pulse; toggles RUN/PAUSED
- clr  in  1  debounced one-cycle pulse; synchronous clear of the time to 00:00
- adj  in  1  level; 1 = adjust mode
- sel  in  1  level; 0 = adjust minutes, 1 = adjust seconds
- sec_1  out  4  seconds ones digit, BCD
- sec_2  out  4  seconds tens digit, BCD
- min_1  out  4  minutes ones digit, BCD
- min_2  out  4  minutes tens digit, BCD
- running  out  1  1 when in the RUN state
- adj_field  out  2  2'b00 none, 2'b01 minutes, 2'b10 seconds; feeds the blink logic

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All digits 0, so display reads 00:00.
  - running = RUN_AT_RESET.
  - adj_field = 0.
  - Release is synchronous to clk.
- States: RUN and PAUSED.
  - pause pulse toggles the state.
  - The toggle takes effect on the next clk edge and is honoured in adjust mode too.
- Normal count (adj=0, RUN, tick_1hz=1):
  - Seconds increment in BCD.
  - At SEC_MAX, seconds wrap to 00 and minutes increment.
  - At MIN_MAX with seconds wrap, the whole time wraps to 00:00.
- PAUSED with adj=0: tick_1hz is ignored and digits hold.
- Adjust mode (adj=1):
  - tick_1hz is ignored in both RUN and PAUSED.
  - On tick_2hz, the field chosen by sel increments in BCD. It wraps at its MAX to 00 with no carry into the other field.
  - The other field holds.
- adj_field is registered:
  - adj=0 gives 2'b00.
  - adj=1, sel=0 gives 2'b01.
  - adj=1, sel=1 gives 2'b10.
- Leaving adjust mode: counting resumes on the next tick_1hz if RUN. There is no partial-second carry-over.
- Priority within one cycle: clr > increment.
  - clr together with a tick gives 00:00; the tick is dropped.
  - clr does not change RUN/PAUSED.
  - clr together with pause clears and toggles.
- sel changing mid-adjust: the new field applies from the next tick_2hz.
- Latency: digits update on the clk edge where the tick is sampled high. Outputs are registered, with no combinational path from inputs to outputs.
- BCD legality: every digit is always 0-9 and the tens digit is never above the MAX tens digit. A ones digit of 9 rolls to 0 with tens +1.
- Illegal states: if a field ever decodes above its MAX, the next increment forces it to 00.

Decomposition:
- Shared package (stopwatch_pkg), holding:
  - BCD digit width constant (4)
  - default SEC_MAX and MIN_MAX
  - adj_field encodings ADJ_NONE, ADJ_MIN, ADJ_SEC
  - state encodings ST_RUN, ST_PAUSED
- One sub-module, bcd_field_counter: a two-digit BCD counter.
  - Parameter: MAX.
  - Inputs: clk, rst_n, clr, inc.
  - Outputs: ones, tens, and a one-cycle wrap flag asserted when inc lands on MAX.
  - Instantiated twice, for seconds and minutes.
- Top level holds the RUN/PAUSED FSM, inc steering and adj_field register.

Test Plan:
- Reset then 61 tick_1hz pulses in RUN -> digits 01:01 (min_2=0, min_1=1, sec_2=0, sec_1=1); running=1.
- Preload 59:58 via adjust, then adj=0 and 2 tick_1hz -> 00:00 with both fields wrapped; no spurious extra increment.
- pause pulse then 10 tick_1hz -> digits unchanged, running=0; second pause plus 1 tick -> sec_1 advances by 1.
- adj=1, sel=1, seconds at 59, one tick_2hz -> seconds 00 with minutes unchanged; adj_field=2'b10. Then sel=0 and 3 tick_2hz -> minutes +3, adj_field=2'b01.
- At 12:34, clr and tick_1hz asserted in the same cycle -> 00:00 next edge; RUN/PAUSED unchanged.
- rst_n pulsed low mid-count asynchronously at 07:19 -> outputs 00:00 immediately (before the next clk edge); adj_field=0; running=RUN_AT_RESET.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants and encodings for the stopwatch timekeeping core.
package stopwatch_pkg;

   localparam int DIGIT_W     = 4;
   localparam int SEC_MAX_DEF = 59;
   localparam int MIN_MAX_DEF = 59;

   typedef enum logic [1:0] {
      ADJ_NONE = 2'b00,
      ADJ_MIN  = 2'b01,
      ADJ_SEC  = 2'b10
   } adj_field_e;

   typedef enum logic {
      ST_PAUSED = 1'b0,
      ST_RUN    = 1'b1
   } state_e;

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit BCD counter that wraps from MAX to 00.
// The wrap flag is combinational so the next field can be carried into
// on the same clock edge.
module bcd_field_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX = 59
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] ones,
   output logic [DIGIT_W-1:0] tens,
   output logic               wrap
);

   localparam logic [7:0] MAX_V = 8'(MAX);

   logic [DIGIT_W-1:0] ones_q, ones_d;
   logic [DIGIT_W-1:0] tens_q, tens_d;
   logic [7:0]         value;
   logic               at_max;
   logic               illegal;

   // Decode the current field and flag values that can only come from corruption.
   always_comb begin
      value   = 8'(tens_q) * 8'd10 + 8'(ones_q);
      at_max  = (value == MAX_V);
      illegal = (ones_q > 4'd9) || (tens_q > 4'd9) || (value > MAX_V);
   end

   // Next digit values; clear outranks increment, and an out-of-range field recovers to 00.
   always_comb begin
      ones_d = ones_q;
      tens_d = tens_q;
      wrap   = 1'b0;
      if (clr) begin
         ones_d = '0;
         tens_d = '0;
      end else if (inc) begin
         if (illegal || at_max) begin
            ones_d = '0;
            tens_d = '0;
            wrap   = at_max && !illegal;
         end else if (ones_q == 4'd9) begin
            ones_d = '0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   // Digit registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_q <= '0;
         tens_q <= '0;
      end else begin
         ones_q <= ones_d;
         tens_q <= tens_d;
      end
   end

   assign ones = ones_q;
   assign tens = tens_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: RUN/PAUSED control, normal counting on the 1 Hz
// tick and carry-free per-field adjustment on the 2 Hz tick.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int SEC_MAX      = SEC_MAX_DEF,
   parameter int MIN_MAX      = MIN_MAX_DEF,
   parameter bit RUN_AT_RESET = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_1hz,
   input  logic               tick_2hz,
   input  logic               pause,
   input  logic               clr,
   input  logic               adj,
   input  logic               sel,
   output logic [DIGIT_W-1:0] sec_1,
   output logic [DIGIT_W-1:0] sec_2,
   output logic [DIGIT_W-1:0] min_1,
   output logic [DIGIT_W-1:0] min_2,
   output logic               running,
   output logic [1:0]         adj_field
);

   localparam state_e RESET_STATE = RUN_AT_RESET ? ST_RUN : ST_PAUSED;

   state_e     state_q, state_d;
   adj_field_e adj_field_q, adj_field_d;
   logic       sec_inc;
   logic       min_inc;
   logic       sec_wrap;
   logic       min_wrap;

   // RUN/PAUSED next state; the pause pulse toggles regardless of mode or clear.
   always_comb begin
      state_d = state_q;
      if (pause) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
      end
   end

   // Steer increments: adjust mode bumps one field with no carry, otherwise seconds carry into minutes.
   always_comb begin
      sec_inc = 1'b0;
      min_inc = 1'b0;
      if (adj) begin
         sec_inc = tick_2hz && sel;
         min_inc = tick_2hz && !sel;
      end else begin
         sec_inc = tick_1hz && (state_q == ST_RUN);
         min_inc = sec_wrap;
      end
   end

   // Which field the blink logic should flash.
   always_comb begin
      adj_field_d = ADJ_NONE;
      if (adj) begin
         adj_field_d = sel ? ADJ_SEC : ADJ_MIN;
      end
   end

   // State and adjust-field registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_STATE;
         adj_field_q <= ADJ_NONE;
      end else begin
         state_q     <= state_d;
         adj_field_q <= adj_field_d;
      end
   end

   bcd_field_counter #(.MAX(SEC_MAX)) u_sec (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (sec_inc),
      .ones  (sec_1),
      .tens  (sec_2),
      .wrap  (sec_wrap)
   );

   bcd_field_counter #(.MAX(MIN_MAX)) u_min (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (min_inc),
      .ones  (min_1),
      .tens  (min_2),
      .wrap  (min_wrap)
   );

   // The minutes wrap needs no action: the seconds/minutes wrap already lands on 00:00.
   logic unused_min_wrap;
   assign unused_min_wrap = min_wrap;

   assign running   = (state_q == ST_RUN);
   assign adj_field = adj_field_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter.
module tb_stopwatch_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1hz;
   logic       tick_2hz;
   logic       pause;
   logic       clr;
   logic       adj;
   logic       sel;
   logic [3:0] sec_1;
   logic [3:0] sec_2;
   logic [3:0] min_1;
   logic [3:0] min_2;
   logic       running;
   logic [1:0] adj_field;

   int vectors     = 0;
   int miscompares = 0;

   stopwatch_counter #(
      .SEC_MAX      (59),
      .MIN_MAX      (59),
      .RUN_AT_RESET (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_1hz  (tick_1hz),
      .tick_2hz  (tick_2hz),
      .pause     (pause),
      .clr       (clr),
      .adj       (adj),
      .sel       (sel),
      .sec_1     (sec_1),
      .sec_2     (sec_2),
      .min_1     (min_1),
      .min_2     (min_2),
      .running   (running),
      .adj_field (adj_field)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Pulse the given inputs for one clock, n times, with an idle clock between pulses.
   task automatic applyStimulus(input logic t1, input logic t2, input logic p,
                                input logic c, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick_1hz = t1;
         tick_2hz = t2;
         pause    = p;
         clr      = c;
         @(negedge clk);
         tick_1hz = 1'b0;
         tick_2hz = 1'b0;
         pause    = 1'b0;
         clr      = 1'b0;
      end
   endtask

   // Change adjust mode/field and let one edge register adj_field.
   task automatic setMode(input logic a, input logic s);
      @(negedge clk);
      adj = a;
      sel = s;
      @(negedge clk);
   endtask

   // Compare MM:SS (as 16'hMMSS), running and adj_field against expectations.
   task automatic checkOutput(input string tag, input logic [15:0] expTime,
                              input logic expRun, input logic [1:0] expAdj);
      logic [15:0] obsTime;
      obsTime = {min_2, min_1, sec_2, sec_1};
      vectors++;
      assert (obsTime === expTime) else begin
         miscompares++;
         $error("[TB] FAIL %s time: observed %h expected %h", tag, obsTime, expTime);
      end
      vectors++;
      assert (running === expRun) else begin
         miscompares++;
         $error("[TB] FAIL %s running: observed %b expected %b", tag, running, expRun);
      end
      vectors++;
      assert (adj_field === expAdj) else begin
         miscompares++;
         $error("[TB] FAIL %s adj_field: observed %b expected %b", tag, adj_field, expAdj);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      tick_1hz = 1'b0;
      tick_2hz = 1'b0;
      pause    = 1'b0;
      clr      = 1'b0;
      adj      = 1'b0;
      sel      = 1'b0;

      #12;
      checkOutput("reset", 16'h0000, 1'b1, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 61);
      checkOutput("count61", 16'h0101, 1'b1, 2'b00);

      setMode(1'b1, 1'b0);
      checkOutput("adj_min_mode", 16'h0101, 1'b1, 2'b01);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
      checkOutput("tick1_ignored_in_adj", 16'h0101, 1'b1, 2'b01);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 58);
      checkOutput("preload_min59", 16'h5901, 1'b1, 2'b01);
      setMode(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 57);
      checkOutput("preload_5958", 16'h5958, 1'b1, 2'b10);
      setMode(1'b0, 1'b0);
      checkOutput("leave_adj", 16'h5958, 1'b1, 2'b00);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("to_5959", 16'h5959, 1'b1, 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("full_wrap", 16'h0000, 1'b1, 2'b00);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3);
      checkOutput("no_spurious_inc", 16'h0000, 1'b1, 2'b00);

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
      checkOutput("paused", 16'h0000, 1'b0, 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
      checkOutput("paused_hold", 16'h0000, 1'b0, 2'b00);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("resumed", 16'h0001, 1'b1, 2'b00);

      setMode(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 58);
      checkOutput("adj_sec59", 16'h0059, 1'b1, 2'b10);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("adj_sec_wrap_nocarry", 16'h0000, 1'b1, 2'b10);
      setMode(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3);
      checkOutput("adj_min_plus3", 16'h0300, 1'b1, 2'b01);
      setMode(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("adj_sec_only", 16'h0301, 1'b1, 2'b10);
      setMode(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 57);
      checkOutput("adj_min_wrap_nocarry", 16'h0001, 1'b1, 2'b01);

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12);
      setMode(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 33);
      setMode(1'b0, 1'b0);
      checkOutput("at_1234", 16'h1234, 1'b1, 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1);
      checkOutput("clr_beats_tick", 16'h0000, 1'b1, 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("count_after_clr", 16'h0001, 1'b1, 2'b00);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1);
      checkOutput("clr_and_pause", 16'h0000, 1'b0, 2'b00);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
      checkOutput("unpause", 16'h0000, 1'b1, 2'b00);

      setMode(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7);
      setMode(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 18);
      setMode(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("at_0719", 16'h0719, 1'b1, 2'b00);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
      setMode(1'b1, 1'b1);
      checkOutput("pre_reset", 16'h0719, 1'b0, 2'b10);

      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 16'h0000, 1'b1, 2'b00);
      @(negedge clk);
      adj   = 1'b0;
      sel   = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
